// File: rtl/pipe_hazard_ctrl_pkg.sv
// pa_pipe_pkg: shared types and constants for the pipeline hazard controller
package pa_pipe_pkg;
   typedef enum logic {RUN, MUL_BUSY} mul_st_e;
   localparam int REG_ZERO    = 0;
   localparam int MUL_LAT_DEF = 5;
endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// pipe_hazard_ctrl_if: pipeline status inputs and decoupler controls of the hazard controller
interface pipe_hazard_ctrl_if #(parameter int REG_W = 5, parameter int CNT_W = 32);
   logic             D_valid;
   logic [REG_W-1:0] D_rs1;
   logic [REG_W-1:0] D_rs2;
   logic             D_rs1_used;
   logic             D_rs2_used;
   logic             A_valid;
   logic [REG_W-1:0] A_regDst;
   logic             A_isLoad;
   logic             A_isMul;
   logic             A_brTaken;
   logic             C_miss;
   logic             C_fillDone;
   logic             hold_FD;
   logic             hold_DA;
   logic             bubble_DA;
   logic             flush_FD;
   logic             flush_DA;
   logic             freeze;
   logic [CNT_W-1:0] stall_cnt;
   modport master (
      output D_valid, D_rs1, D_rs2, D_rs1_used, D_rs2_used, A_valid, A_regDst,
             A_isLoad, A_isMul, A_brTaken, C_miss, C_fillDone,
      input  hold_FD, hold_DA, bubble_DA, flush_FD, flush_DA, freeze, stall_cnt
   );
   modport slave (
      input  D_valid, D_rs1, D_rs2, D_rs1_used, D_rs2_used, A_valid, A_regDst,
             A_isLoad, A_isMul, A_brTaken, C_miss, C_fillDone,
      output hold_FD, hold_DA, bubble_DA, flush_FD, flush_DA, freeze, stall_cnt
   );
endinterface

// File: rtl/pipe_hazard_ctrl_ld_use_detect.sv
// ld_use_detect: flags a D-stage read of the register a live A-stage load is about to write
module ld_use_detect
   import pa_pipe_pkg::*;
#(parameter int REG_W = 5) (
   input  logic             D_valid,
   input  logic [REG_W-1:0] D_rs1,
   input  logic [REG_W-1:0] D_rs2,
   input  logic             D_rs1_used,
   input  logic             D_rs2_used,
   input  logic             A_valid,
   input  logic [REG_W-1:0] A_regDst,
   input  logic             A_isLoad,
   output logic             hazard
);
   assign hazard = A_valid & A_isLoad & (A_regDst != REG_W'(REG_ZERO)) & D_valid &
                   ((D_rs1_used & (D_rs1 == A_regDst)) | (D_rs2_used & (D_rs2 == A_regDst)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze controller with MUL occupancy FSM and saturating stall counter
module pipe_hazard_ctrl
   import pa_pipe_pkg::*;
#(
   parameter int REG_W   = 5,
   parameter int MUL_LAT = MUL_LAT_DEF,
   parameter int CNT_W   = 32
) (
   input logic               clk,
   input logic               reset,
   pipe_hazard_ctrl_if.slave bus
);
   localparam int MCW = (MUL_LAT > 2) ? $clog2(MUL_LAT - 1) : 1;
   mul_st_e          state, state_n;
   logic [MCW-1:0]   mcnt, mcnt_n;
   logic             miss_pend;
   logic [CNT_W-1:0] stall_cnt;
   logic             frz, br, mul_start, mul_go, mul_h, lu_raw, lu_h;
   ld_use_detect #(.REG_W(REG_W)) u_ld_use (
      .D_valid    (bus.D_valid),
      .D_rs1      (bus.D_rs1),
      .D_rs2      (bus.D_rs2),
      .D_rs1_used (bus.D_rs1_used),
      .D_rs2_used (bus.D_rs2_used),
      .A_valid    (bus.A_valid),
      .A_regDst   (bus.A_regDst),
      .A_isLoad   (bus.A_isLoad),
      .hazard     (lu_raw)
   );
   // a new miss is ignored once pending, so pending-or-new reduces to a single OR
   assign frz       = ~reset & ~bus.C_fillDone & (bus.C_miss | miss_pend);
   assign br        = ~reset & ~frz & bus.A_valid & bus.A_brTaken;
   assign mul_start = (state == RUN) & bus.A_valid & bus.A_isMul & (MUL_LAT > 1);
   assign mul_go    = ~frz & ~br & mul_start;
   assign mul_h     = ~reset & ~frz & ~br & (mul_start | ((state == MUL_BUSY) & (mcnt != '0)));
   assign lu_h      = ~reset & ~frz & ~br & ~mul_h & lu_raw;
   assign bus.freeze    = frz;
   assign bus.flush_FD  = reset | br;
   assign bus.flush_DA  = reset | br;
   assign bus.hold_FD   = mul_h | lu_h;
   assign bus.hold_DA   = mul_h;
   assign bus.bubble_DA = lu_h;
   assign bus.stall_cnt = stall_cnt;
   // MUL occupancy next state; frozen entirely while the D-cache miss is outstanding
   always_comb begin
      state_n = mul_go ? MUL_BUSY :
                (~frz & (state == MUL_BUSY) & (mcnt == '0)) ? RUN : state;
      mcnt_n  = mul_go ? MCW'(MUL_LAT - 2) :
                (~frz & (state == MUL_BUSY) & (mcnt != '0)) ? mcnt - MCW'(1) : mcnt;
   end
   // state registers, miss tracking and saturating stall-cycle count
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= RUN;
         mcnt      <= '0;
         miss_pend <= 1'b0;
         stall_cnt <= '0;
      end else begin
         state     <= state_n;
         mcnt      <= mcnt_n;
         miss_pend <= bus.C_fillDone ? 1'b0 : (miss_pend | bus.C_miss);
         if ((frz | bus.hold_FD) && !(&stall_cnt)) stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench for the hazard controller plus a narrow-counter saturation instance
module tb_pipe_hazard_ctrl;
   logic clk = 1'b0;
   logic reset = 1'b1;
   int   total = 0;
   int   bad = 0;
   // expected control vector order: {hold_FD, hold_DA, bubble_DA, flush_FD, flush_DA, freeze}
   localparam logic [5:0] NONE = 6'b000000;
   localparam logic [5:0] LU   = 6'b101000;
   localparam logic [5:0] MULH = 6'b110000;
   localparam logic [5:0] BR   = 6'b000110;
   localparam logic [5:0] FRZ  = 6'b000001;
   localparam logic [5:0] RST  = 6'b000110;
   typedef struct {
      string       tag;
      logic [5:0]  ctl;
      logic [31:0] cnt;
   } exp_t;
   exp_t sb[$];
   pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(32)) bus();
   pipe_hazard_ctrl_if #(.REG_W(5), .CNT_W(3))  sbus();
   pipe_hazard_ctrl #(.REG_W(5), .MUL_LAT(5), .CNT_W(32)) dut (.clk(clk), .reset(reset), .bus(bus));
   pipe_hazard_ctrl #(.REG_W(5), .MUL_LAT(1), .CNT_W(3)) u_sat (.clk(clk), .reset(reset), .bus(sbus));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   task automatic drv(input logic dv, input logic [4:0] r1, input logic u1, input logic [4:0] r2,
                      input logic u2, input logic av, input logic [4:0] rd, input logic ld,
                      input logic mul, input logic br, input logic miss, input logic fill);
      bus.D_valid = dv; bus.D_rs1 = r1; bus.D_rs1_used = u1; bus.D_rs2 = r2; bus.D_rs2_used = u2;
      bus.A_valid = av; bus.A_regDst = rd; bus.A_isLoad = ld; bus.A_isMul = mul;
      bus.A_brTaken = br; bus.C_miss = miss; bus.C_fillDone = fill;
   endtask
   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask
   task automatic cyc(input string tag, input logic [5:0] ctl, input int cnt);
      exp_t e;
      sb.push_back('{tag, ctl, 32'(cnt)});
      @(negedge clk);
      e = sb.pop_front();
      chk({e.tag, ".ctl"}, 32'({bus.hold_FD, bus.hold_DA, bus.bubble_DA, bus.flush_FD, bus.flush_DA, bus.freeze}), 32'(e.ctl));
      chk({e.tag, ".cnt"}, bus.stall_cnt, e.cnt);
      @(posedge clk);
      #1;
   endtask
   initial begin
      idle();
      sbus.D_valid = 0; sbus.D_rs1 = 0; sbus.D_rs1_used = 0; sbus.D_rs2 = 0; sbus.D_rs2_used = 0;
      sbus.A_valid = 0; sbus.A_regDst = 0; sbus.A_isLoad = 0; sbus.A_isMul = 0;
      sbus.A_brTaken = 0; sbus.C_miss = 0; sbus.C_fillDone = 0;
      cyc("reset", RST, 0);
      reset = 1'b0;
      cyc("idle0", NONE, 0);
      drv(1, 3, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0); cyc("lu_rs1", LU, 0);
      idle(); cyc("lu_after", NONE, 1);
      drv(1, 0, 1, 0, 0, 1, 0, 1, 0, 0, 0, 0); cyc("lu_r0", NONE, 1);
      drv(1, 4, 1, 3, 1, 1, 3, 1, 0, 0, 0, 0); cyc("lu_rs2", LU, 1);
      drv(1, 4, 1, 3, 0, 1, 3, 1, 0, 0, 0, 0); cyc("lu_rs2_unused", NONE, 2);
      drv(0, 3, 1, 3, 1, 1, 3, 1, 0, 0, 0, 0); cyc("lu_d_invalid", NONE, 2);
      drv(1, 3, 1, 0, 0, 1, 3, 1, 0, 1, 0, 0); cyc("br_over_lu", BR, 2);
      idle(); cyc("br_after", NONE, 2);
      drv(0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 0);
      for (int i = 0; i < 4; i++) cyc($sformatf("mul_hold%0d", i), MULH, 2 + i);
      cyc("mul_release", NONE, 6);
      idle(); cyc("mul_after", NONE, 6);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 6; i++) cyc($sformatf("miss%0d", i), FRZ, 6 + i);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); cyc("fill_done", NONE, 12);
      idle(); cyc("fill_after", NONE, 12);
      drv(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1); cyc("miss_hit", NONE, 12);
      idle(); cyc("miss_hit_after", NONE, 12);
      drv(0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 0);
      cyc("mulm0", MULH, 12);
      cyc("mulm1", MULH, 13);
      drv(0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 1, 0);
      for (int i = 0; i < 3; i++) cyc($sformatf("mulm_frz%0d", i), FRZ, 14 + i);
      drv(0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 1); cyc("mulm_fill", MULH, 17);
      drv(0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 0); cyc("mulm_last", MULH, 18);
      cyc("mulm_release", NONE, 19);
      idle(); cyc("mulm_after", NONE, 19);
      drv(1, 3, 1, 0, 0, 1, 3, 1, 0, 1, 1, 0); cyc("prio_frz", FRZ, 19);
      drv(1, 3, 1, 0, 0, 1, 3, 1, 0, 1, 0, 1); cyc("prio_br", BR, 20);
      drv(1, 3, 1, 0, 0, 1, 3, 1, 0, 0, 0, 0); cyc("prio_lu", LU, 20);
      idle(); cyc("prio_after", NONE, 21);
      drv(0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 0, 0); cyc("rst_mul", MULH, 21);
      drv(0, 0, 0, 0, 0, 1, 7, 0, 1, 0, 1, 0); cyc("rst_miss", FRZ, 22);
      reset = 1'b1; cyc("rst_async", RST, 0);
      reset = 1'b0; idle(); cyc("rst_clean0", NONE, 0);
      cyc("rst_clean1", NONE, 0);
      sbus.A_valid = 1; sbus.A_isMul = 1;
      @(negedge clk);
      chk("sat_mul1_hold", 32'({sbus.hold_FD, sbus.hold_DA}), 0);
      chk("sat_cnt0", 32'(sbus.stall_cnt), 0);
      @(posedge clk); #1;
      sbus.A_valid = 0; sbus.A_isMul = 0; sbus.C_miss = 1;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         chk($sformatf("sat_frz%0d", k), 32'(sbus.freeze), 1);
         chk($sformatf("sat_cnt%0d", k), 32'(sbus.stall_cnt), (k < 7) ? k : 7);
         @(posedge clk); #1;
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
